// File: rtl/fft_frame_scheduler.sv
// Frame launch scheduler above the FFT core: queues frame requests, issues fft_go
// pulses, watchdogs fft_busy and keeps frame statistics (latency stats under FFT_SCHED_STATS_EN).
module fft_frame_scheduler #(
  parameter int FFT_SIZE      = 4096,
  parameter int PEND_DEPTH    = 2,
  parameter int START_TIMEOUT = 16,
  parameter int RUN_TIMEOUT   = 8 * FFT_SIZE * $clog2(FFT_SIZE),
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sched_en,
  input  logic                 frame_req,
  output logic                 frame_ack,
  output logic                 fft_go,
  input  logic                 fft_busy,
  output logic                 frame_done,
  output logic                 sched_busy,
  output logic [1:0]           pending,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic                 timeout_err,
  input  logic                 err_clear,
  output logic [CNT_WIDTH-1:0] last_latency,
  output logic [CNT_WIDTH-1:0] max_latency
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_ARM, S_RUN, S_DONE, S_ERROR
  } state_e;

  localparam int             WD_MAX    = (RUN_TIMEOUT > START_TIMEOUT) ? RUN_TIMEOUT : START_TIMEOUT;
  localparam int             WD_W      = $clog2(WD_MAX + 1);
  localparam logic [WD_W-1:0] START_LIM = WD_W'(START_TIMEOUT - 1);
  localparam logic [WD_W-1:0] RUN_LIM   = WD_W'(RUN_TIMEOUT - 1);
  localparam logic [1:0]      DEPTH     = 2'(PEND_DEPTH);

  state_e                 state_q, state_d;
  logic [1:0]             pending_q, pending_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [CNT_WIDTH-1:0]   frame_count_q, frame_count_d;
  logic [CNT_WIDTH-1:0]   drop_count_q, drop_count_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   accept;

  assign fft_go      = (state_q == S_LAUNCH);
  assign frame_done  = (state_q == S_DONE);
  assign sched_busy  = (state_q != S_IDLE);
  assign pending     = pending_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign timeout_err = timeout_err_q;

  // A launch frees a slot in the same cycle, so a full queue still accepts then.
  assign accept    = frame_req && (state_q != S_ERROR) && ((pending_q < DEPTH) || fft_go);
  assign frame_ack = accept;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;

    unique case (state_q)
      S_IDLE:   if (sched_en && (pending_q != 2'd0) && !fft_busy) state_d = S_LAUNCH;
      S_LAUNCH: begin
        state_d = S_ARM;
        wd_d    = WD_W'(1);
      end
      S_ARM: begin
        if (fft_busy) begin
          state_d = S_RUN;
          wd_d    = '0;
        end else if (wd_q == START_LIM) begin
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!fft_busy)            state_d = S_DONE;
        else if (wd_q == RUN_LIM) state_d = S_ERROR;
        else                      wd_d    = wd_q + 1'b1;
      end
      S_DONE: begin
        state_d       = S_IDLE;
        frame_count_d = frame_count_q + 1'b1;
      end
      S_ERROR:  if (err_clear) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (frame_req && !accept && (drop_count_q != '1)) drop_count_d = drop_count_q + 1'b1;

    // Queue is flushed on the way into ERROR and held empty while there.
    if (state_d == S_ERROR) pending_d = 2'd0;
    else                    pending_d = pending_q + {1'b0, accept} - {1'b0, fft_go};

    timeout_err_d = (state_d == S_ERROR);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here
  // would make results depend on process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pending_q     <= 2'd0;
      wd_q          <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      wd_q          <= wd_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef FFT_SCHED_STATS_EN
  logic [CNT_WIDTH-1:0] lat_q, lat_d;
  logic [CNT_WIDTH-1:0] last_q, last_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;

  // Latency counts from the launch cycle and saturates rather than wrapping.
  always_comb begin
    lat_d  = lat_q;
    last_d = last_q;
    max_d  = max_q;
    if (state_q == S_LAUNCH) begin
      lat_d = '0;
    end else if ((state_q == S_ARM) || (state_q == S_RUN)) begin
      if (lat_q != '1) lat_d = lat_q + 1'b1;
    end
    if (state_q == S_DONE) begin
      last_d = lat_q;
      if (lat_q > max_q) max_d = lat_q;
    end
    if (err_clear) max_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_q  <= '0;
      last_q <= '0;
      max_q  <= '0;
    end else begin
      lat_q  <= lat_d;
      last_q <= last_d;
      max_q  <= max_d;
    end
  end

  assign last_latency = last_q;
  assign max_latency  = max_q;
`else
  assign last_latency = '0;
  assign max_latency  = '0;
`endif

endmodule
